// File: rtl/bg_row_streamer.sv
// Per-frame background row generator: solid, board grid, checker or border, streamed one row per handshake.
// Optional BG_AUTO_REPEAT_EN: restart row 0 after each frame and apply start requests at frame boundaries.
module bg_row_streamer #(
  parameter int ROWS      = 40,
  parameter int ROW_BITS  = 256,
  parameter int LINE_W    = 2,
  parameter int CELL_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic                      fill,
  input  logic                      row_ready,
  output logic                      row_valid,
  output logic [0:ROW_BITS-1]       row_data,
  output logic [$clog2(ROWS)-1:0]   row_idx,
  output logic                      sof,
  output logic                      eof,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int IDX_W = $clog2(ROWS);
  localparam int R1    = ROWS / 3;
  localparam int R2    = 2 * ROWS / 3;
  localparam int C1    = ROW_BITS / 3;
  localparam int C2    = 2 * ROW_BITS / 3;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROWS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [0:ROW_BITS-1] pattern_row(input logic [1:0] m, input logic f,
                                                      input int r);
    logic [0:ROW_BITS-1] v;
    logic                row_line;
    v        = '0;
    row_line = (r >= R1 && r < R1 + LINE_W) || (r >= R2 && r < R2 + LINE_W);
    for (int c = 0; c < ROW_BITS; c++) begin
      case (m)
        2'd0: v[c] = f;
        2'd1: v[c] = row_line || (c >= C1 && c < C1 + LINE_W) || (c >= C2 && c < C2 + LINE_W);
        2'd2: v[c] = (((r >> CELL_LOG2) ^ (c >> CELL_LOG2)) & 1) != 0;
        default: v[c] = (r == 0) || (r == ROWS - 1) || (c == 0) || (c == ROW_BITS - 1);
      endcase
    end
    return v;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic                fill_q, fill_d;
  logic                row_valid_q, row_valid_d;
  logic [0:ROW_BITS-1] row_data_q, row_data_d;
  logic [IDX_W-1:0]    row_idx_q, row_idx_d;
  logic [IDX_W-1:0]    idx_inc;
  logic                sof_q, sof_d;
  logic                eof_q, eof_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
`ifdef BG_AUTO_REPEAT_EN
  logic                pend_q, pend_d;
  logic [1:0]          pend_mode_q, pend_mode_d;
  logic                pend_fill_q, pend_fill_d;
  logic [1:0]          new_mode;
  logic                new_fill;
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    fill_d       = fill_q;
    row_valid_d  = row_valid_q;
    row_data_d   = row_data_q;
    row_idx_d    = row_idx_q;
    sof_d        = sof_q;
    eof_d        = eof_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    idx_inc      = row_idx_q + 1'b1;
`ifdef BG_AUTO_REPEAT_EN
    pend_d       = pend_q;
    pend_mode_d  = pend_mode_q;
    pend_fill_d  = pend_fill_q;
    new_mode     = start ? mode : (pend_q ? pend_mode_q : mode_q);
    new_fill     = start ? fill : (pend_q ? pend_fill_q : fill_q);
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = STREAM;
          mode_d      = mode;
          fill_d      = fill;
          row_valid_d = 1'b1;
          row_idx_d   = '0;
          sof_d       = 1'b1;
          eof_d       = (LAST == '0);
          busy_d      = 1'b1;
          row_data_d  = pattern_row(mode, fill, 0);
        end
      end
      default: begin
`ifdef BG_AUTO_REPEAT_EN
        if (start) begin
          pend_d      = 1'b1;
          pend_mode_d = mode;
          pend_fill_d = fill;
        end
`endif
        if (row_ready) begin
          if (row_idx_q == LAST) begin
            frame_done_d = 1'b1;
`ifdef BG_AUTO_REPEAT_EN
            // Wrap straight into row 0 of the next frame; any pending request takes effect here.
            pend_d      = 1'b0;
            mode_d      = new_mode;
            fill_d      = new_fill;
            row_idx_d   = '0;
            sof_d       = 1'b1;
            eof_d       = (LAST == '0);
            row_data_d  = pattern_row(new_mode, new_fill, 0);
`else
            state_d     = IDLE;
            row_valid_d = 1'b0;
            row_idx_d   = '0;
            row_data_d  = '0;
            sof_d       = 1'b0;
            eof_d       = 1'b0;
            busy_d      = 1'b0;
`endif
          end else begin
            row_idx_d  = idx_inc;
            sof_d      = 1'b0;
            eof_d      = (idx_inc == LAST);
            row_data_d = pattern_row(mode_q, fill_q, int'(idx_inc));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= 2'd0;
      fill_q       <= 1'b0;
      row_valid_q  <= 1'b0;
      row_data_q   <= '0;
      row_idx_q    <= '0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef BG_AUTO_REPEAT_EN
      pend_q       <= 1'b0;
      pend_mode_q  <= 2'd0;
      pend_fill_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      fill_q       <= fill_d;
      row_valid_q  <= row_valid_d;
      row_data_q   <= row_data_d;
      row_idx_q    <= row_idx_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef BG_AUTO_REPEAT_EN
      pend_q       <= pend_d;
      pend_mode_q  <= pend_mode_d;
      pend_fill_q  <= pend_fill_d;
`endif
    end
  end

  assign row_valid  = row_valid_q;
  assign row_data   = row_data_q;
  assign row_idx    = row_idx_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bg_row_streamer.sv
// Directed bench for bg_row_streamer with default parameters (40 rows x 256 bits).
module tb_bg_row_streamer;

  localparam int ROWS = 40;

  logic         clk = 1'b0;
  logic         rst, start, fill, row_ready;
  logic [1:0]   mode;
  logic         row_valid, sof, eof, busy, frame_done;
  logic [0:255] row_data;
  logic [5:0]   row_idx;

  int n_cmp = 0;
  int n_bad = 0;
  logic [0:255] cap [ROWS];

  always #5 clk = ~clk;

  bg_row_streamer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fill(fill), .row_ready(row_ready),
    .row_valid(row_valid), .row_data(row_data), .row_idx(row_idx), .sof(sof), .eof(eof),
    .busy(busy), .frame_done(frame_done)
  );

  typedef struct {
    logic [1:0] mode;
    logic       fill;
    int         row;
    int         bit_i;
    logic       exp_bit;
    int         exp_pop;
  } vec_t;

  vec_t vecs [24];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a frame, streams it with row_ready held high, captures every row.
  // Returns in the cycle where frame_done is visible.
  task automatic run_frame(input logic [1:0] m, input logic f);
    int n, cyc;
    logic seq_ok;
    mode = m; fill = f; start = 1'b1; row_ready = 1'b1;
    step();
    start = 1'b0;
    chk("latency_row0", {row_valid, sof, busy, (row_idx == 6'd0)}, 4'b1111);
    n = 0; cyc = 0; seq_ok = 1'b1;
    while (n < ROWS && cyc < 200) begin
      if (row_valid && row_ready) begin
        if (int'(row_idx) != n || sof !== (n == 0) || eof !== (n == ROWS - 1) || !busy)
          seq_ok = 1'b0;
        cap[n] = row_data;
        n++;
      end
      step();
      cyc++;
    end
    chk("handshakes", n, ROWS);
    chk("idx_sof_eof_seq", seq_ok, 1'b1);
    chk("frame_done_pulse", {frame_done, row_valid, busy, eof}, 4'b1000);
  endtask

  initial begin
    logic [0:255] saved;
    int n, cyc;
    logic bp_done, held_ok;

    vecs[0]  = '{2'd0, 1'b0, 0,   0,   1'b0, 0};
    vecs[1]  = '{2'd0, 1'b0, 39,  255, 1'b0, 0};
    vecs[2]  = '{2'd0, 1'b1, 17,  100, 1'b1, 256};
    vecs[3]  = '{2'd1, 1'b0, 13,  0,   1'b1, 256};
    vecs[4]  = '{2'd1, 1'b0, 14,  200, 1'b1, 256};
    vecs[5]  = '{2'd1, 1'b0, 26,  3,   1'b1, 256};
    vecs[6]  = '{2'd1, 1'b0, 27,  255, 1'b1, 256};
    vecs[7]  = '{2'd1, 1'b0, 12,  85,  1'b1, 4};
    vecs[8]  = '{2'd1, 1'b0, 15,  86,  1'b1, 4};
    vecs[9]  = '{2'd1, 1'b0, 0,   84,  1'b0, 4};
    vecs[10] = '{2'd1, 1'b0, 28,  171, 1'b1, 4};
    vecs[11] = '{2'd1, 1'b0, 39,  172, 1'b0, 4};
    vecs[12] = '{2'd2, 1'b0, 0,   7,   1'b0, 128};
    vecs[13] = '{2'd2, 1'b0, 0,   8,   1'b1, 128};
    vecs[14] = '{2'd2, 1'b0, 0,   15,  1'b1, 128};
    vecs[15] = '{2'd2, 1'b0, 8,   0,   1'b1, 128};
    vecs[16] = '{2'd2, 1'b0, 8,   8,   1'b0, 128};
    vecs[17] = '{2'd3, 1'b0, 0,   128, 1'b1, 256};
    vecs[18] = '{2'd3, 1'b0, 39,  0,   1'b1, 256};
    vecs[19] = '{2'd3, 1'b0, 1,   0,   1'b1, 2};
    vecs[20] = '{2'd3, 1'b0, 1,   255, 1'b1, 2};
    vecs[21] = '{2'd3, 1'b0, 1,   1,   1'b0, 2};
    vecs[22] = '{2'd3, 1'b0, 20,  254, 1'b0, 2};
    vecs[23] = '{2'd3, 1'b0, 38,  255, 1'b1, 2};

    rst = 1'b1; start = 1'b0; mode = 2'd0; fill = 1'b0; row_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_ctrl", {row_valid, sof, eof, busy, frame_done}, 5'b0);
    chk("reset_idx", row_idx, 6'd0);
    chk("reset_data", row_data, 256'd0);

    // Frames are chained: each start lands in the frame_done cycle of the previous one.
    for (int i = 0; i < 24; i++) begin
      if (i == 0 || vecs[i].mode != vecs[i-1].mode || vecs[i].fill != vecs[i-1].fill)
        run_frame(vecs[i].mode, vecs[i].fill);
      chk($sformatf("vec%0d_bit", i), cap[vecs[i].row][vecs[i].bit_i], vecs[i].exp_bit);
      chk($sformatf("vec%0d_pop", i), $countones(cap[vecs[i].row]), vecs[i].exp_pop);
    end
    step();
    chk("frame_done_one_cycle", {frame_done, busy}, 2'b00);

    // Backpressure at row 5 with a mid-frame start and mode change.
    mode = 2'd1; fill = 1'b0; start = 1'b1; row_ready = 1'b1;
    step();
    start = 1'b0;
    n = 0; cyc = 0; bp_done = 1'b0; held_ok = 1'b1;
    while (n < ROWS && cyc < 200) begin
      if (row_valid && row_idx == 6'd5 && !bp_done) begin
        bp_done = 1'b1;
        saved = row_data;
        row_ready = 1'b0; start = 1'b1; mode = 2'd2; fill = 1'b1;
        step();
        start = 1'b0;
        if (!row_valid || row_idx != 6'd5 || row_data !== saved || !busy) held_ok = 1'b0;
        step();
        if (!row_valid || row_idx != 6'd5 || row_data !== saved || !busy) held_ok = 1'b0;
        row_ready = 1'b1;
        cyc += 2;
      end
      if (row_valid && row_ready) begin
        cap[n] = row_data;
        n++;
      end
      step();
      cyc++;
    end
    chk("bp_row5_held", held_ok, 1'b1);
    chk("bp_handshakes", n, ROWS);
    chk("bp_row5_idx_ok", cap[5], saved);
    chk("bp_row6_pop", $countones(cap[6]), 4);
    chk("bp_mode_latched", $countones(cap[13]), 256);
    chk("bp_frame_done", {frame_done, row_valid, busy}, 3'b100);
    step();

    // Reset in the middle of a frame.
    mode = 2'd3; fill = 1'b0; start = 1'b1; row_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!(row_valid && row_idx == 6'd20) && cyc < 100) begin
      step();
      cyc++;
    end
    chk("reached_row20", row_idx, 6'd20);
    rst = 1'b1;
    step();
    chk("midrst_ctrl", {row_valid, sof, eof, busy, frame_done}, 5'b0);
    chk("midrst_idx", row_idx, 6'd0);
    chk("midrst_data", row_data, 256'd0);
    rst = 1'b0;
    step();
    chk("midrst_no_done", {frame_done, row_valid}, 2'b00);
    run_frame(2'd2, 1'b0);
    chk("post_rst_row0_bit8", cap[0][8], 1'b1);
    chk("post_rst_row0_bit0", cap[0][0], 1'b0);
    chk("post_rst_row8_bit0", cap[8][0], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
